// File: rtl/memory_arbiter_pkg.sv
// Shared types and bus widths for the instruction/data memory arbiter.
package memory_arbiter_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int SEL_W  = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DATA  = 2'd2
    } arbiter_state_t;

    typedef enum logic {
        REQ_FETCH = 1'b0,
        REQ_DATA  = 1'b1
    } requester_t;

endpackage

// File: rtl/memory_arbiter_bus_timeout.sv
// Wait-cycle counter for one bus transfer; expired marks the last allowed cycle.
module bus_timeout #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic count_enable,
    output logic expired
);

    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] r_count;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (count_enable) begin
            r_count <= r_count + CW'(1);
        end
    end

    assign expired = (r_count == LAST);

endmodule

// File: rtl/memory_arbiter.sv
// Round-robin arbiter sharing one Wishbone-classic master port between
// the instruction fetch and load/store requesters.
module memory_arbiter
    import memory_arbiter_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              fetch_request,
    input  logic [ADDR_W-1:0] fetch_address,
    output logic              fetch_ready,
    output logic [DATA_W-1:0] fetch_data,
    output logic              fetch_error,
    input  logic              data_request,
    input  logic              data_write_enable,
    input  logic [ADDR_W-1:0] data_address,
    input  logic [DATA_W-1:0] data_write_data,
    input  logic [SEL_W-1:0]  data_select,
    output logic              data_ready,
    output logic [DATA_W-1:0] data_read_data,
    output logic              data_error,
    output logic              bus_cycle,
    output logic              bus_strobe,
    output logic              bus_write_enable,
    output logic [ADDR_W-1:0] bus_address,
    output logic [DATA_W-1:0] bus_write_data,
    output logic [SEL_W-1:0]  bus_select,
    input  logic [DATA_W-1:0] bus_read_data,
    input  logic              bus_acknowledge,
    input  logic              bus_error
);

    arbiter_state_t    r_state;
    requester_t        r_last_grant;
    logic [ADDR_W-1:0] r_addr;
    logic              r_we;
    logic [DATA_W-1:0] r_wdata;
    logic [SEL_W-1:0]  r_sel;

    arbiter_state_t    w_next_state;
    requester_t        w_grant_who;
    logic              w_grant;
    logic              w_busy;
    logic              w_done;
    logic              w_fail;
    logic              w_expired;

    assign w_busy = (r_state != ST_IDLE);
    assign w_done = w_busy && (bus_acknowledge || bus_error || w_expired);
    assign w_fail = bus_error || w_expired;

    bus_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clock       (clock),
        .reset       (reset),
        .clear       (!w_busy || w_done),
        .count_enable(w_busy),
        .expired     (w_expired)
    );

    always_comb begin
        w_grant      = 1'b0;
        w_grant_who  = REQ_FETCH;
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (fetch_request && data_request) begin
                    w_grant     = 1'b1;
                    w_grant_who = (r_last_grant == REQ_DATA) ?
                                  REQ_FETCH : REQ_DATA;
                end else if (fetch_request) begin
                    w_grant     = 1'b1;
                    w_grant_who = REQ_FETCH;
                end else if (data_request) begin
                    w_grant     = 1'b1;
                    w_grant_who = REQ_DATA;
                end
            end
            // Back-to-back hand-off only ever goes to the other requester.
            ST_FETCH: begin
                if (w_done && data_request) begin
                    w_grant     = 1'b1;
                    w_grant_who = REQ_DATA;
                end
            end
            ST_DATA: begin
                if (w_done && fetch_request) begin
                    w_grant     = 1'b1;
                    w_grant_who = REQ_FETCH;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
        if (w_grant) begin
            w_next_state = (w_grant_who == REQ_FETCH) ? ST_FETCH : ST_DATA;
        end else if (w_done) begin
            w_next_state = ST_IDLE;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state      <= ST_IDLE;
            r_last_grant <= REQ_DATA;
            r_addr       <= '0;
            r_we         <= 1'b0;
            r_wdata      <= '0;
            r_sel        <= '0;
        end else begin
            r_state <= w_next_state;
            // Only arbitration from IDLE moves the round-robin pointer.
            if (w_grant && r_state == ST_IDLE) begin
                r_last_grant <= w_grant_who;
            end
            if (w_grant) begin
                if (w_grant_who == REQ_FETCH) begin
                    r_addr  <= fetch_address;
                    r_we    <= 1'b0;
                    r_wdata <= '0;
                    r_sel   <= '1;
                end else begin
                    r_addr  <= data_address;
                    r_we    <= data_write_enable;
                    r_wdata <= data_write_data;
                    r_sel   <= data_select;
                end
            end
        end
    end

    assign bus_cycle        = w_busy;
    assign bus_strobe       = w_busy;
    assign bus_write_enable = w_busy && r_we;
    assign bus_address      = r_addr;
    assign bus_write_data   = r_wdata;
    assign bus_select       = r_sel;

    // A requester that dropped its request early gets no ready pulse.
    assign fetch_ready = w_done && (r_state == ST_FETCH) && fetch_request;
    assign fetch_error = fetch_ready && w_fail;
    assign fetch_data  = (fetch_ready && !w_fail) ? bus_read_data : '0;

    assign data_ready     = w_done && (r_state == ST_DATA) && data_request;
    assign data_error     = data_ready && w_fail;
    assign data_read_data = (data_ready && !w_fail) ? bus_read_data : '0;

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed self-checking bench for memory_arbiter with a hand-driven bus slave.
module tb_memory_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic        fetch_request;
    logic [31:0] fetch_address;
    logic        fetch_ready;
    logic [31:0] fetch_data;
    logic        fetch_error;
    logic        data_request;
    logic        data_write_enable;
    logic [31:0] data_address;
    logic [31:0] data_write_data;
    logic [3:0]  data_select;
    logic        data_ready;
    logic [31:0] data_read_data;
    logic        data_error;
    logic        bus_cycle;
    logic        bus_strobe;
    logic        bus_write_enable;
    logic [31:0] bus_address;
    logic [31:0] bus_write_data;
    logic [3:0]  bus_select;
    logic [31:0] bus_read_data;
    logic        bus_acknowledge;
    logic        bus_error;

    int errors = 0;
    int checks = 0;

    always #5 clock = ~clock;

    memory_arbiter #(.TIMEOUT_CYCLES(16)) dut (
        .clock            (clock),
        .reset            (reset),
        .fetch_request    (fetch_request),
        .fetch_address    (fetch_address),
        .fetch_ready      (fetch_ready),
        .fetch_data       (fetch_data),
        .fetch_error      (fetch_error),
        .data_request     (data_request),
        .data_write_enable(data_write_enable),
        .data_address     (data_address),
        .data_write_data  (data_write_data),
        .data_select      (data_select),
        .data_ready       (data_ready),
        .data_read_data   (data_read_data),
        .data_error       (data_error),
        .bus_cycle        (bus_cycle),
        .bus_strobe       (bus_strobe),
        .bus_write_enable (bus_write_enable),
        .bus_address      (bus_address),
        .bus_write_data   (bus_write_data),
        .bus_select       (bus_select),
        .bus_read_data    (bus_read_data),
        .bus_acknowledge  (bus_acknowledge),
        .bus_error        (bus_error)
    );

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset             = 1'b0;
        fetch_request     = 1'b0;
        fetch_address     = '0;
        data_request      = 1'b0;
        data_write_enable = 1'b0;
        data_address      = '0;
        data_write_data   = '0;
        data_select       = '0;
        bus_read_data     = '0;
        bus_acknowledge   = 1'b0;
        bus_error         = 1'b0;

        // Reset state
        #1;
        chk("rst_cyc", bus_cycle, 0);
        chk("rst_stb", bus_strobe, 0);
        chk("rst_we", bus_write_enable, 0);
        chk("rst_frdy", fetch_ready, 0);
        chk("rst_drdy", data_ready, 0);
        chk("rst_addr", bus_address, 0);
        chk("rst_sel", bus_select, 0);
        step();
        step();
        reset = 1'b1;

        // Zero-wait fetch
        fetch_request = 1'b1;
        fetch_address = 32'h0000_0100;
        step();
        bus_acknowledge = 1'b1;
        bus_read_data   = 32'h0000_0013;
        #1;
        chk("f0_cyc", bus_cycle, 1);
        chk("f0_addr", bus_address, 32'h100);
        chk("f0_sel", bus_select, 4'hF);
        chk("f0_we", bus_write_enable, 0);
        chk("f0_rdy", fetch_ready, 1);
        chk("f0_data", fetch_data, 32'h13);
        chk("f0_err", fetch_error, 0);
        step();
        fetch_request   = 1'b0;
        bus_acknowledge = 1'b0;
        #1;
        chk("f0_idle", bus_cycle, 0);
        chk("f0_rdy_off", fetch_ready, 0);

        // Contention after a fresh reset: FETCH first, DATA back-to-back
        reset = 1'b0;
        step();
        reset = 1'b1;
        fetch_request     = 1'b1;
        fetch_address     = 32'h0000_0200;
        data_request      = 1'b1;
        data_write_enable = 1'b0;
        data_address      = 32'h0000_0300;
        step();
        bus_acknowledge = 1'b1;
        bus_read_data   = 32'h0000_0011;
        #1;
        chk("c1_addr", bus_address, 32'h200);
        chk("c1_frdy", fetch_ready, 1);
        chk("c1_fdata", fetch_data, 32'h11);
        chk("c1_drdy", data_ready, 0);
        step();
        fetch_request = 1'b0;
        bus_read_data = 32'h0000_0022;
        #1;
        chk("c1_b2b_cyc", bus_cycle, 1);
        chk("c1_daddr", bus_address, 32'h300);
        chk("c1_drdy2", data_ready, 1);
        chk("c1_ddata", data_read_data, 32'h22);
        chk("c1_frdy2", fetch_ready, 0);
        step();
        data_request    = 1'b0;
        bus_acknowledge = 1'b0;
        #1;
        chk("c1_idle", bus_cycle, 0);

        // Repeat contention: DATA first
        fetch_request = 1'b1;
        fetch_address = 32'h0000_0204;
        data_request  = 1'b1;
        data_address  = 32'h0000_0304;
        step();
        bus_acknowledge = 1'b1;
        bus_read_data   = 32'h0000_0033;
        #1;
        chk("c2_addr", bus_address, 32'h304);
        chk("c2_drdy", data_ready, 1);
        chk("c2_ddata", data_read_data, 32'h33);
        chk("c2_frdy", fetch_ready, 0);
        step();
        data_request  = 1'b0;
        bus_read_data = 32'h0000_0044;
        #1;
        chk("c2_faddr", bus_address, 32'h204);
        chk("c2_frdy2", fetch_ready, 1);
        chk("c2_fdata", fetch_data, 32'h44);
        step();
        fetch_request   = 1'b0;
        bus_acknowledge = 1'b0;
        #1;
        chk("c2_idle", bus_cycle, 0);

        // Store with 3 wait states
        data_request      = 1'b1;
        data_write_enable = 1'b1;
        data_address      = 32'h0000_2000;
        data_write_data   = 32'hDEAD_BEEF;
        data_select       = 4'b0011;
        step();
        for (int k = 1; k <= 4; k++) begin
            bus_acknowledge = (k == 4);
            #1;
            chk("st_we", bus_write_enable, 1);
            chk("st_sel", bus_select, 4'b0011);
            chk("st_wdata", bus_write_data, 32'hDEAD_BEEF);
            chk("st_addr", bus_address, 32'h2000);
            chk("st_rdy", data_ready, (k == 4));
            if (k == 4) chk("st_err", data_error, 0);
            if (k < 4) step();
        end
        step();
        data_request      = 1'b0;
        data_write_enable = 1'b0;
        bus_acknowledge   = 1'b0;
        #1;
        chk("st_idle", bus_cycle, 0);

        // Load timeout after 16 bus cycles
        data_request  = 1'b1;
        data_address  = 32'h0000_4000;
        data_select   = 4'hF;
        bus_read_data = 32'hFFFF_FFFF;
        step();
        for (int k = 1; k <= 16; k++) begin
            #1;
            chk("to_cyc", bus_cycle, 1);
            chk("to_rdy", data_ready, (k == 16));
            if (k == 16) begin
                chk("to_err", data_error, 1);
                chk("to_data", data_read_data, 0);
            end
            if (k < 16) step();
        end
        step();
        data_request = 1'b0;
        #1;
        chk("to_idle", bus_cycle, 0);

        // Bus error together with acknowledge during a fetch
        fetch_request = 1'b1;
        fetch_address = 32'h0000_0400;
        step();
        bus_error       = 1'b1;
        bus_acknowledge = 1'b1;
        bus_read_data   = 32'h0000_ABCD;
        #1;
        chk("be_rdy", fetch_ready, 1);
        chk("be_err", fetch_error, 1);
        chk("be_data", fetch_data, 0);
        step();
        fetch_request   = 1'b0;
        bus_error       = 1'b0;
        bus_acknowledge = 1'b0;
        #1;
        chk("be_idle", bus_cycle, 0);

        // Reset in the second wait cycle of a load
        data_request  = 1'b1;
        data_address  = 32'h0000_5000;
        bus_read_data = 32'h0000_0055;
        step();
        #1;
        chk("mr_cyc1", bus_cycle, 1);
        step();
        reset = 1'b0;
        #1;
        chk("mr_cyc", bus_cycle, 0);
        chk("mr_stb", bus_strobe, 0);
        chk("mr_rdy", data_ready, 0);
        step();
        chk("mr_rdy2", data_ready, 0);
        reset = 1'b1;
        step();
        bus_acknowledge = 1'b1;
        #1;
        chk("mr_new_addr", bus_address, 32'h5000);
        chk("mr_new_rdy", data_ready, 1);
        chk("mr_new_data", data_read_data, 32'h55);
        chk("mr_new_err", data_error, 0);
        step();
        data_request    = 1'b0;
        bus_acknowledge = 1'b0;
        #1;
        chk("mr_idle", bus_cycle, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
